// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: WIDTH-bit A + B + cin, with the carry chain cut
// into STAGES registered slices of SW bits each. Valid/ready handshakes on
// both sides. One global advance lets a stalled output freeze the whole pipe.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int SW = WIDTH / STAGES;

  // Reject geometries that cannot be sliced evenly.
  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_geometry
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
           WIDTH, STAGES);
  end

  // Per-stage state. Operand registers hold the not-yet-added upper bits,
  // shifted down so the next stage always finds its slice in the low SW bits.
  logic              adv;
  logic              valid_reg [STAGES];
  logic              carry_reg [STAGES];
  logic [WIDTH-1:0]  opa_reg   [STAGES];
  logic [WIDTH-1:0]  opb_reg   [STAGES];
  logic [WIDTH-1:0]  sum_reg   [STAGES];

  // The pipeline only moves when the last stage is empty or being drained.
  assign adv     = !valid_reg[STAGES-1] || m_ready;
  assign s_ready = adv;

  assign m_valid = valid_reg[STAGES-1];
  assign sum     = sum_reg[STAGES-1];
  assign carry   = carry_reg[STAGES-1];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] opa_in;
      logic [WIDTH-1:0] opb_in;
      logic [WIDTH-1:0] sum_in;
      logic             carry_in;
      logic             valid_in;
      logic [SW:0]      slice_next;
      logic [WIDTH-1:0] sum_next;

      if (gi == 0) begin : g_first
        // First slice takes the raw operands and the external carry-in.
        assign opa_in   = A;
        assign opb_in   = B;
        assign sum_in   = '0;
        assign carry_in = cin;
        assign valid_in = s_valid;
      end else begin : g_chain
        // Later slices ripple the registered carry from the stage before.
        assign opa_in   = opa_reg[gi-1];
        assign opb_in   = opb_reg[gi-1];
        assign sum_in   = sum_reg[gi-1];
        assign carry_in = carry_reg[gi-1];
        assign valid_in = valid_reg[gi-1];
      end

      // Slice add: SW-bit sum plus carry out in the top bit.
      assign slice_next = {1'b0, opa_in[SW-1:0]} + {1'b0, opb_in[SW-1:0]}
                        + {{SW{1'b0}}, carry_in};

      // Merge this slice's result into the partial sum carried forward.
      always_comb begin
        sum_next = sum_in;
        sum_next[gi*SW +: SW] = slice_next[SW-1:0];
      end

      // Stage register: cleared on reset, frozen when the pipe is stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
          carry_reg[gi] <= 1'b0;
          opa_reg[gi]   <= '0;
          opb_reg[gi]   <= '0;
          sum_reg[gi]   <= '0;
        end else if (adv) begin
          valid_reg[gi] <= valid_in;
          carry_reg[gi] <= slice_next[SW];
          opa_reg[gi]   <= opa_in >> SW;
          opb_reg[gi]   <= opb_in >> SW;
          sum_reg[gi]   <= sum_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: default 8/2 instance for the handshake
// and arithmetic cases, plus 16/4 and 8/1 instances for latency and random
// operands checked against A+B+cin.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=8, STAGES=2
  logic       s_valid, s_ready, cin, m_valid, m_ready, carry;
  logic [7:0] a, b, sum;

  // WIDTH=16, STAGES=4
  logic        v16, sr16, c16, mv16, mr16, co16;
  logic [15:0] a16, b16, s16;

  // WIDTH=8, STAGES=1
  logic       v1, sr1, c1, mv1, mr1, co1;
  logic [7:0] a1, b1, s1;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  logic [7:0]  t3_a [4] = '{8'h01, 8'h03, 8'h80, 8'h7F};
  logic [7:0]  t3_b [4] = '{8'h02, 8'h04, 8'h80, 8'h01};
  logic [7:0]  t3_s [4] = '{8'h03, 8'h07, 8'h00, 8'h80};
  logic        t3_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [16:0] q16[$];
  logic [8:0]  q1[$];
  logic [16:0] exp16;
  logic [8:0]  exp1;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .A(a), .B(b), .cin(cin), .m_valid(m_valid), .m_ready(m_ready),
    .sum(sum), .carry(carry)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .s_valid(v16), .s_ready(sr16),
    .A(a16), .B(b16), .cin(c16), .m_valid(mv16), .m_ready(mr16),
    .sum(s16), .carry(co16)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(v1), .s_ready(sr1),
    .A(a1), .B(b1), .cin(c1), .m_valid(mv1), .m_ready(mr1),
    .sum(s1), .carry(co1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 0; a = 0; b = 0; cin = 0; m_ready = 1;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0; mr16 = 1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0; mr1 = 1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("reset m_valid", m_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset carry", carry, 0);
    chk("reset s_ready", s_ready, 1);
    chk("reset m_valid 16/4", mv16, 0);
    chk("reset m_valid 8/1", mv1, 0);
    $display("reset: m_valid=%0d sum=%0h carry=%0d s_ready=%0d", m_valid, sum, carry, s_ready);

    // 1: wrap, latency 2
    a = 8'hFF; b = 8'h01; cin = 0; s_valid = 1;
    step();
    s_valid = 0; a = 0; b = 0; cin = 0;
    chk("t1 not early", m_valid, 0);
    step();
    chk("t1 m_valid", m_valid, 1);
    chk("t1 sum", sum, 8'h00);
    chk("t1 carry", carry, 1);
    $display("t1: FF+01+0 -> sum=%0h carry=%0d", sum, carry);
    step();
    chk("t1 drained", m_valid, 0);

    // 2: carry across slice boundary, then all-ones
    a = 8'h0F; b = 8'h00; cin = 1; s_valid = 1;
    step();
    a = 8'hFF; b = 8'hFF; cin = 1;
    step();
    s_valid = 0; a = 0; b = 0; cin = 0;
    chk("t2a m_valid", m_valid, 1);
    chk("t2a sum", sum, 8'h10);
    chk("t2a carry", carry, 0);
    $display("t2a: 0F+00+1 -> sum=%0h carry=%0d", sum, carry);
    step();
    chk("t2b m_valid", m_valid, 1);
    chk("t2b sum", sum, 8'hFF);
    chk("t2b carry", carry, 1);
    $display("t2b: FF+FF+1 -> sum=%0h carry=%0d", sum, carry);
    step();

    // 3: back-to-back stream
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        s_valid = 1; a = t3_a[i]; b = t3_b[i]; cin = 0;
      end else begin
        s_valid = 0; a = 0; b = 0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        chk("t3 m_valid", m_valid, 1);
        chk("t3 sum", sum, t3_s[i-1]);
        chk("t3 carry", carry, t3_c[i-1]);
        $display("t3[%0d]: sum=%0h carry=%0d", i-1, sum, carry);
      end
    end
    chk("t3 drained", m_valid, 0);

    // 4: backpressure
    m_ready = 0;
    a = 8'h01; b = 8'h02; cin = 0; s_valid = 1;
    step();
    a = 8'h03; b = 8'h04;
    step();
    a = 8'h05; b = 8'h06;
    for (int i = 0; i < 3; i++) begin
      chk("t4 stall s_ready", s_ready, 0);
      chk("t4 stall m_valid", m_valid, 1);
      chk("t4 stall sum", sum, 8'h03);
      $display("t4 stall %0d: s_ready=%0d sum=%0h", i, s_ready, sum);
      step();
    end
    m_ready = 1;
    #1;
    chk("t4 release s_ready", s_ready, 1);
    step();
    s_valid = 0; a = 0; b = 0;
    chk("t4 q1 m_valid", m_valid, 1);
    chk("t4 q1 sum", sum, 8'h07);
    $display("t4 release: sum=%0h", sum);
    step();
    chk("t4 q2 m_valid", m_valid, 1);
    chk("t4 q2 sum", sum, 8'h0B);
    $display("t4 release: sum=%0h", sum);
    step();
    chk("t4 drained", m_valid, 0);

    // 5: reset discards in-flight result
    a = 8'h10; b = 8'h20; cin = 0; s_valid = 1;
    step();
    s_valid = 0; a = 0; b = 0;
    rst = 1;
    step();
    rst = 0;
    chk("t5 rst m_valid", m_valid, 0);
    chk("t5 rst sum", sum, 0);
    chk("t5 rst carry", carry, 0);
    step();
    chk("t5 +1 m_valid", m_valid, 0);
    chk("t5 +1 sum", sum, 0);
    step();
    chk("t5 +2 m_valid", m_valid, 0);
    chk("t5 +2 sum", sum, 0);
    $display("t5: after reset m_valid=%0d sum=%0h", m_valid, sum);

    // 6a: 16/4 latency and random stream
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1; v16 = 1; mr16 = 1;
    step();
    v16 = 0;
    lat = 1;
    while (!mv16 && lat < 10) begin
      step();
      lat++;
    end
    chk("t6 latency 16/4", lat, 4);
    chk("t6 first 16/4", {co16, s16}, 17'h10001);
    $display("t6 16/4: latency=%0d result=%0h", lat, {co16, s16});
    step();
    for (int i = 0; i < 40; i++) begin
      v16 = (i < 30) && ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom_range(0, 1));
      mr16 = ($urandom_range(0, 3) != 0);
      #1;
      if (v16 && sr16) q16.push_back(17'(a16) + 17'(b16) + 17'(c16));
      if (mv16 && mr16) begin
        if (q16.size() > 0) exp16 = q16.pop_front();
        else exp16 = 'x;
        chk("t6 16/4 result", {co16, s16}, exp16);
        $display("t6 16/4: got %0h exp %0h", {co16, s16}, exp16);
      end
      step();
    end
    v16 = 0; mr16 = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mv16) begin
        if (q16.size() > 0) exp16 = q16.pop_front();
        else exp16 = 'x;
        chk("t6 16/4 drain", {co16, s16}, exp16);
        $display("t6 16/4 drain: got %0h exp %0h", {co16, s16}, exp16);
      end
      step();
    end
    chk("t6 16/4 all emitted", q16.size(), 0);

    // 6b: 8/1 latency and random stream
    a1 = 8'h80; b1 = 8'h80; c1 = 1; v1 = 1; mr1 = 1;
    step();
    v1 = 0;
    lat = 1;
    while (!mv1 && lat < 10) begin
      step();
      lat++;
    end
    chk("t6 latency 8/1", lat, 1);
    chk("t6 first 8/1", {co1, s1}, 9'h101);
    $display("t6 8/1: latency=%0d result=%0h", lat, {co1, s1});
    step();
    for (int i = 0; i < 40; i++) begin
      v1 = (i < 30) && ($urandom_range(0, 3) != 0);
      a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom_range(0, 1));
      mr1 = ($urandom_range(0, 3) != 0);
      #1;
      if (v1 && sr1) q1.push_back(9'(a1) + 9'(b1) + 9'(c1));
      if (mv1 && mr1) begin
        if (q1.size() > 0) exp1 = q1.pop_front();
        else exp1 = 'x;
        chk("t6 8/1 result", {co1, s1}, exp1);
        $display("t6 8/1: got %0h exp %0h", {co1, s1}, exp1);
      end
      step();
    end
    v1 = 0; mr1 = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mv1) begin
        if (q1.size() > 0) exp1 = q1.pop_front();
        else exp1 = 'x;
        chk("t6 8/1 drain", {co1, s1}, exp1);
        $display("t6 8/1 drain: got %0h exp %0h", {co1, s1}, exp1);
      end
      step();
    end
    chk("t6 8/1 all emitted", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
